// File: rtl/register_file_mp.sv
// Multi-read-port register file with a power-on clear sequence and a
// handshaked debug dump of the whole array.
//
// Ports:
//   clk, i_rst_n          rising-edge clock, asynchronous active-low reset
//   i_reg_write           write enable
//   i_write_register      write address
//   i_write_data          write data
//   i_read_addr           NUM_READ packed read addresses (port k at k*ADDR_BITS)
//   o_read_data           NUM_READ packed registered read data (port k at k*DATA_BITS)
//   o_busy                clear sequence in progress
//   i_dump_start          one-cycle dump request
//   o_dump_valid          dump word valid
//   i_dump_ready          consumer accepts dump word
//   o_dump_addr           index of the presented register
//   o_dump_data           contents of the presented register (live from the array)
//   o_dump_last           presented word is the last register
module register_file_mp #(
   parameter int unsigned DATA_BITS = 32,
   parameter int unsigned ADDR_BITS = 5,
   parameter int unsigned NUM_READ  = 2,
   parameter int unsigned ZERO_REG  = 1
) (
   input  logic                          clk,
   input  logic                          i_rst_n,
   input  logic                          i_reg_write,
   input  logic [ADDR_BITS-1:0]          i_write_register,
   input  logic [DATA_BITS-1:0]          i_write_data,
   input  logic [NUM_READ*ADDR_BITS-1:0] i_read_addr,
   output logic [NUM_READ*DATA_BITS-1:0] o_read_data,
   output logic                          o_busy,
   input  logic                          i_dump_start,
   output logic                          o_dump_valid,
   input  logic                          i_dump_ready,
   output logic [ADDR_BITS-1:0]          o_dump_addr,
   output logic [DATA_BITS-1:0]          o_dump_data,
   output logic                          o_dump_last
);

   localparam int unsigned DEPTH = 2 ** ADDR_BITS;
   localparam logic [ADDR_BITS-1:0] LAST_ADDR = ADDR_BITS'(DEPTH - 1);

   typedef enum logic {CLEAR, READY} clr_state_t;
   typedef enum logic {IDLE, DUMP}   dump_state_t;

   logic [DATA_BITS-1:0]          mem [DEPTH];
   clr_state_t                    clr_state;
   logic [ADDR_BITS-1:0]          clr_cnt;
   logic                          busy_q;
   dump_state_t                   dump_state;
   logic [ADDR_BITS-1:0]          dump_idx;
   logic [NUM_READ*DATA_BITS-1:0] rd_q;
   logic [ADDR_BITS-1:0]          raddr [NUM_READ];
   logic                          zero_waddr;
   logic                          wr_en;
   logic                          dump_active;

   // Unpack read addresses per port
   for (genvar k = 0; k < NUM_READ; k++) begin : g_raddr
      assign raddr[k] = i_read_addr[k*ADDR_BITS +: ADDR_BITS];
   end

   // External writes are accepted only once the clear sequence is done
   assign zero_waddr = (ZERO_REG == 1) && (i_write_register == '0);
   assign wr_en      = i_reg_write && (clr_state == READY) && !zero_waddr;

   // Clear FSM: walks the counter over every register, then goes READY
   always_ff @(posedge clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         clr_state <= CLEAR;
         clr_cnt   <= '0;
         busy_q    <= 1'b1;
      end else if (clr_state == CLEAR) begin
         clr_cnt <= clr_cnt + ADDR_BITS'(1);
         if (clr_cnt == LAST_ADDR) begin
            clr_state <= READY;
            busy_q    <= 1'b0;
         end
      end
   end

   assign o_busy = busy_q;

   // Storage array: no reset, zeroed only by the clear walk
   always_ff @(posedge clk) begin
      if (clr_state == CLEAR) begin
         mem[clr_cnt] <= '0;
      end else if (wr_en) begin
         mem[i_write_register] <= i_write_data;
      end
   end

   // Registered read ports with write-first bypass; register 0 never bypasses
   always_ff @(posedge clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         rd_q <= '0;
      end else begin
         for (int unsigned k = 0; k < NUM_READ; k++) begin
            if ((clr_state == CLEAR) || ((ZERO_REG == 1) && (raddr[k] == '0))) begin
               rd_q[k*DATA_BITS +: DATA_BITS] <= '0;
            end else if (wr_en && (raddr[k] == i_write_register)) begin
               rd_q[k*DATA_BITS +: DATA_BITS] <= i_write_data;
            end else begin
               rd_q[k*DATA_BITS +: DATA_BITS] <= mem[raddr[k]];
            end
         end
      end
   end

   assign o_read_data = rd_q;

   // Dump FSM: index advances only on a valid/ready handshake
   always_ff @(posedge clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         dump_state <= IDLE;
         dump_idx   <= '0;
      end else if (dump_state == IDLE) begin
         if (i_dump_start && !busy_q) begin
            dump_state <= DUMP;
            dump_idx   <= '0;
         end
      end else if (i_dump_ready) begin
         if (dump_idx == LAST_ADDR) begin
            dump_state <= IDLE;
            dump_idx   <= '0;
         end else begin
            dump_idx <= dump_idx + ADDR_BITS'(1);
         end
      end
   end

   // Dump data is read live from the array so writes show up immediately
   assign dump_active  = (dump_state == DUMP);
   assign o_dump_valid = dump_active;
   assign o_dump_addr  = dump_active ? dump_idx : '0;
   assign o_dump_data  = dump_active ? mem[dump_idx] : '0;
   assign o_dump_last  = dump_active && (dump_idx == LAST_ADDR);

endmodule

// File: tb/tb_register_file_mp.sv
module tb_register_file_mp;

   logic        clk;
   logic        i_rst_n;
   logic        i_reg_write;
   logic [4:0]  i_write_register;
   logic [31:0] i_write_data;
   logic [9:0]  i_read_addr;
   logic [63:0] o_read_data;
   logic        o_busy;
   logic        i_dump_start;
   logic        o_dump_valid;
   logic        i_dump_ready;
   logic [4:0]  o_dump_addr;
   logic [31:0] o_dump_data;
   logic        o_dump_last;

   int n_cmp = 0;
   int n_err = 0;

   register_file_mp dut (
      .clk              (clk),
      .i_rst_n          (i_rst_n),
      .i_reg_write      (i_reg_write),
      .i_write_register (i_write_register),
      .i_write_data     (i_write_data),
      .i_read_addr      (i_read_addr),
      .o_read_data      (o_read_data),
      .o_busy           (o_busy),
      .i_dump_start     (i_dump_start),
      .o_dump_valid     (o_dump_valid),
      .i_dump_ready     (i_dump_ready),
      .o_dump_addr      (o_dump_addr),
      .o_dump_data      (o_dump_data),
      .o_dump_last      (o_dump_last)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // One clock edge; inputs are driven and outputs sampled on the falling edge
   task automatic tick();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic set_raddr(input logic [4:0] p1, input logic [4:0] p0);
      i_read_addr = {p1, p0};
   endtask

   // Count cycles with busy high, checking that reads and dump stay quiet
   task automatic clear_walk(input string tag);
      int cnt;
      cnt = 0;
      while (o_busy && cnt < 40) begin
         check({tag, "_rd0"}, o_read_data[31:0], 32'h0);
         check({tag, "_rd1"}, o_read_data[63:32], 32'h0);
         check({tag, "_dvalid"}, 32'(o_dump_valid), 32'h0);
         cnt++;
         tick();
      end
      check({tag, "_busy_cycles"}, 32'(cnt), 32'd32);
   endtask

   logic [31:0] em [32];
   int          exp_idx;
   bit          done;
   bit          wrote7;
   bit          wr_now;

   initial begin
      i_rst_n          = 1'b0;
      i_reg_write      = 1'b0;
      i_write_register = '0;
      i_write_data     = '0;
      i_read_addr      = '0;
      i_dump_start     = 1'b0;
      i_dump_ready     = 1'b0;
      tick();
      tick();

      // Reset state
      check("rst_busy",   32'(o_busy), 32'h1);
      check("rst_rd",     o_read_data[31:0], 32'h0);
      check("rst_dvalid", 32'(o_dump_valid), 32'h0);
      check("rst_daddr",  32'(o_dump_addr), 32'h0);
      check("rst_ddata",  o_dump_data, 32'h0);
      check("rst_dlast",  32'(o_dump_last), 32'h0);

      // Clear sequence with a write and a dump request that must be ignored
      i_rst_n          = 1'b1;
      i_reg_write      = 1'b1;
      i_write_register = 5'd3;
      i_write_data     = 32'hFFFF_FFFF;
      i_dump_start     = 1'b1;
      set_raddr(5'd3, 5'd1);
      clear_walk("clr1");
      i_reg_write  = 1'b0;
      i_dump_start = 1'b0;
      tick();
      check("clr1_no_dump", 32'(o_dump_valid), 32'h0);

      // Every address reads zero after clear
      for (int a = 0; a < 32; a++) begin
         set_raddr(5'(31 - a), 5'(a));
         tick();
         check($sformatf("zero_p0_r%0d", a), o_read_data[31:0], 32'h0);
         check($sformatf("zero_p1_r%0d", 31 - a), o_read_data[63:32], 32'h0);
      end

      // Write-first bypass on both ports
      i_reg_write      = 1'b1;
      i_write_register = 5'd5;
      i_write_data     = 32'hDEAD_BEEF;
      set_raddr(5'd5, 5'd5);
      tick();
      i_reg_write = 1'b0;
      check("byp_p0", o_read_data[31:0], 32'hDEAD_BEEF);
      check("byp_p1", o_read_data[63:32], 32'hDEAD_BEEF);
      tick();
      check("r5_p0", o_read_data[31:0], 32'hDEAD_BEEF);
      check("r5_p1", o_read_data[63:32], 32'hDEAD_BEEF);

      // Register 0 is hardwired to zero, no bypass
      i_reg_write      = 1'b1;
      i_write_register = 5'd0;
      i_write_data     = 32'h1234_5678;
      set_raddr(5'd0, 5'd0);
      tick();
      i_reg_write = 1'b0;
      check("r0_same_p0", o_read_data[31:0], 32'h0);
      check("r0_same_p1", o_read_data[63:32], 32'h0);
      tick();
      check("r0_later", o_read_data[31:0], 32'h0);

      // Preload rN = N*3
      for (int n = 0; n < 32; n++) begin
         i_reg_write      = 1'b1;
         i_write_register = 5'(n);
         i_write_data     = 32'(n * 3);
         em[n]            = 32'(n * 3);
         tick();
      end
      i_reg_write = 1'b0;
      set_raddr(5'd31, 5'd10);
      tick();
      check("pre_r10", o_read_data[31:0], 32'd30);
      check("pre_r31", o_read_data[63:32], 32'd93);

      // Full-speed dump; a start pulse mid-dump must be ignored
      i_dump_ready = 1'b1;
      i_dump_start = 1'b1;
      tick();
      i_dump_start = 1'b0;
      for (int k = 0; k < 32; k++) begin
         check($sformatf("d1_valid_%0d", k), 32'(o_dump_valid), 32'h1);
         check($sformatf("d1_addr_%0d", k),  32'(o_dump_addr), 32'(k));
         check($sformatf("d1_data_%0d", k),  o_dump_data, 32'(k * 3));
         check($sformatf("d1_last_%0d", k),  32'(o_dump_last), (k == 31) ? 32'h1 : 32'h0);
         i_dump_start = (k == 5);
         tick();
      end
      i_dump_start = 1'b0;
      check("d1_end_valid", 32'(o_dump_valid), 32'h0);
      check("d1_end_addr",  32'(o_dump_addr), 32'h0);
      check("d1_end_data",  o_dump_data, 32'h0);
      check("d1_end_last",  32'(o_dump_last), 32'h0);

      // Dump with ready toggling and a write to r7 while it is stalled
      i_dump_ready = 1'b0;
      i_dump_start = 1'b1;
      tick();
      i_dump_start = 1'b0;
      exp_idx = 0;
      done    = 1'b0;
      wrote7  = 1'b0;
      for (int cyc = 0; cyc < 200 && !done; cyc++) begin
         check($sformatf("d2_valid_c%0d", cyc), 32'(o_dump_valid), 32'h1);
         check($sformatf("d2_addr_c%0d", cyc),  32'(o_dump_addr), 32'(exp_idx));
         check($sformatf("d2_data_c%0d", cyc),  o_dump_data, em[exp_idx]);
         check($sformatf("d2_last_c%0d", cyc),  32'(o_dump_last), (exp_idx == 31) ? 32'h1 : 32'h0);
         i_dump_ready = cyc[0];
         wr_now = (exp_idx == 7) && !i_dump_ready && !wrote7;
         if (wr_now) begin
            i_reg_write      = 1'b1;
            i_write_register = 5'd7;
            i_write_data     = 32'hA5A5_A5A5;
            wrote7           = 1'b1;
         end
         tick();
         i_reg_write = 1'b0;
         if (wr_now) begin
            em[7] = 32'hA5A5_A5A5;
            check("d2_r7_hold_addr", 32'(o_dump_addr), 32'd7);
            check("d2_r7_new_data",  o_dump_data, 32'hA5A5_A5A5);
         end
         if (i_dump_ready) begin
            if (exp_idx == 31) done = 1'b1;
            else exp_idx++;
         end
      end
      check("d2_completed", 32'(done), 32'h1);
      check("d2_end_valid", 32'(o_dump_valid), 32'h0);

      // Reset in the middle of a dump
      i_dump_ready = 1'b1;
      i_dump_start = 1'b1;
      set_raddr(5'd10, 5'd5);
      tick();
      i_dump_start = 1'b0;
      for (int k = 0; k < 10; k++) tick();
      check("d3_pre_addr", 32'(o_dump_addr), 32'd10);
      check("d3_pre_rd0",  o_read_data[31:0], 32'd15);
      i_rst_n = 1'b0;
      #1;
      check("d3_rst_busy",   32'(o_busy), 32'h1);
      check("d3_rst_rd0",    o_read_data[31:0], 32'h0);
      check("d3_rst_rd1",    o_read_data[63:32], 32'h0);
      check("d3_rst_dvalid", 32'(o_dump_valid), 32'h0);
      check("d3_rst_daddr",  32'(o_dump_addr), 32'h0);
      check("d3_rst_ddata",  o_dump_data, 32'h0);
      check("d3_rst_dlast",  32'(o_dump_last), 32'h0);
      tick();
      i_rst_n      = 1'b1;
      i_dump_start = 1'b1;
      clear_walk("clr2");
      tick();
      i_dump_start = 1'b0;
      check("d4_valid", 32'(o_dump_valid), 32'h1);
      check("d4_addr",  32'(o_dump_addr), 32'h0);
      check("d4_data",  o_dump_data, 32'h0);
      check("d4_rd_r5", o_read_data[31:0], 32'h0);
      check("d4_rd_r10", o_read_data[63:32], 32'h0);
      tick();
      check("d4_addr1",  32'(o_dump_addr), 32'h1);
      check("d4_data1",  o_dump_data, 32'h0);
      for (int k = 0; k < 31; k++) tick();
      check("d4_end_valid", 32'(o_dump_valid), 32'h0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
